// File: rtl/mlp_fixed_pkg.sv
// mlp_fixed_pkg
// Shared fixed-point format helpers for the MLP datapath blocks
// (MAC, activation, pooling).
//   fx_w       : storage width of a fixed-point word (int + frac bits)
//   fx_prod_w  : width of a full-precision product of two words
//   fx_acc_w   : accumulator width (product width + guard MSBs)
//   fx_max/min : signed saturation limits for a given word width
//   DEF_*      : limits for the default Q11.5 format
//   ROUND_*    : encodings of the output rounding mode
package mlp_fixed_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  function automatic int fx_w(input int int_digit, input int dec_digit);
    return int_digit + dec_digit;
  endfunction

  function automatic int fx_prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int fx_acc_w(input int w, input int guard_bits);
    return 2 * w + guard_bits;
  endfunction

  function automatic longint fx_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint fx_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam int     DEF_W   = fx_w(11, 5);
  localparam longint DEF_MAX = fx_max(DEF_W);
  localparam longint DEF_MIN = fx_min(DEF_W);

endpackage

// File: rtl/mlp_fixed_round_sat.sv
// mlp_fixed_round_sat
// Combinational finalize stage: takes a full-precision accumulator value
// (2*DECIMAL_DIGIT fraction bits), optionally rounds half-up, shifts back
// to DECIMAL_DIGIT fraction bits and saturates to a W-bit signed word.
// Ports:
//   i_x   : ACC_W-bit signed accumulator value
//   o_y   : W-bit signed result, same format as the MAC operands
//   o_sat : result was clamped to MAX or MIN
module mlp_fixed_round_sat
  import mlp_fixed_pkg::*;
#(
  parameter int W             = 16,
  parameter int DECIMAL_DIGIT = 5,
  parameter int GUARD_BITS    = 8,
  parameter int ROUND         = ROUND_HALF_UP,
  localparam int ACC_W        = fx_acc_w(W, GUARD_BITS)
) (
  input  logic [ACC_W-1:0] i_x,
  output logic [W-1:0]     o_y,
  output logic             o_sat
);

  // One extra MSB so the rounding increment can never wrap.
  localparam int EXT_W = ACC_W + 1;

  localparam logic signed [EXT_W-1:0] HALF =
    (ROUND == ROUND_HALF_UP) ? (EXT_W'(1) <<< (DECIMAL_DIGIT - 1)) : '0;
  localparam logic signed [EXT_W-1:0] MAX_EXT = EXT_W'(fx_max(W));
  localparam logic signed [EXT_W-1:0] MIN_EXT = EXT_W'(fx_min(W));

  logic signed [EXT_W-1:0] w_rnd;
  logic signed [EXT_W-1:0] w_shf;

  assign w_rnd = $signed({i_x[ACC_W-1], i_x}) + HALF;
  // Arithmetic shift floors toward minus infinity, which is what the
  // truncate mode wants.
  assign w_shf = w_rnd >>> DECIMAL_DIGIT;

  always_comb begin
    o_y   = w_shf[W-1:0];
    o_sat = 1'b0;
    if (w_shf > MAX_EXT) begin
      o_y   = MAX_EXT[W-1:0];
      o_sat = 1'b1;
    end else if (w_shf < MIN_EXT) begin
      o_y   = MIN_EXT[W-1:0];
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/mlp_fixed_mac.sv
// mlp_fixed_mac
// Streaming fixed-point dot-product engine, one per neuron lane.
// Operand pairs are multiplied at full precision (S1), accumulated with
// guard bits (S2), and each vector terminated by in_last produces one
// rounded and saturated result.
// Optional build macro MLP_FIXED_MAC_RELU_EN: clamp negative results to 0
// (with o_out_sat cleared) after saturation.
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   i_in_valid/o_in_ready : operand handshake
//   i_in_a, i_in_b    : W-bit signed operands (Q INT_DIGIT.DECIMAL_DIGIT)
//   i_in_last         : final term of the current vector
//   o_out_valid/i_out_ready : result handshake
//   o_out_data        : W-bit signed result, same format as the operands
//   o_out_sat         : result was clamped, qualified by o_out_valid
module mlp_fixed_mac
  import mlp_fixed_pkg::*;
#(
  parameter int INT_DIGIT     = 11,
  parameter int DECIMAL_DIGIT = 5,
  parameter int GUARD_BITS    = 8,
  parameter int ROUND         = ROUND_HALF_UP,
  localparam int W            = fx_w(INT_DIGIT, DECIMAL_DIGIT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_a,
  input  logic [W-1:0] i_in_b,
  input  logic         i_in_last,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data,
  output logic         o_out_sat
);

  localparam int PROD_W = fx_prod_w(W);
  localparam int ACC_W  = fx_acc_w(W, GUARD_BITS);

  logic              r_rst_done;
  logic              r_s1_valid;
  logic              r_s1_last;
  logic [PROD_W-1:0] r_p;
  logic [ACC_W-1:0]  r_acc;
  logic              r_out_valid;
  logic [W-1:0]      r_out_data;
  logic              r_out_sat;

  logic              w_advance;
  logic              w_in_ready;
  logic              w_accept;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_sum;
  logic [W-1:0]      w_fin_y;
  logic              w_fin_sat;
  logic [W-1:0]      w_res_y;
  logic              w_res_sat;

  // The whole pipeline moves as one; a held result stalls everything.
  assign w_advance  = !r_out_valid || i_out_ready;
  // Input side stays closed for the first cycle after reset release.
  assign w_in_ready = w_advance && r_rst_done;
  assign w_accept   = i_in_valid && w_in_ready;

  // Low 2W bits of the sign-extended product are the exact signed product.
  assign w_prod = {{W{i_in_a[W-1]}}, i_in_a} * {{W{i_in_b[W-1]}}, i_in_b};
  assign w_sum  = r_acc + {{GUARD_BITS{r_p[PROD_W-1]}}, r_p};

  mlp_fixed_round_sat #(
    .W             (W),
    .DECIMAL_DIGIT (DECIMAL_DIGIT),
    .GUARD_BITS    (GUARD_BITS),
    .ROUND         (ROUND)
  ) u_round_sat (
    .i_x   (w_sum),
    .o_y   (w_fin_y),
    .o_sat (w_fin_sat)
  );

`ifdef MLP_FIXED_MAC_RELU_EN
  always_comb begin
    w_res_y   = w_fin_y;
    w_res_sat = w_fin_sat;
    if (w_fin_y[W-1]) begin
      w_res_y   = '0;
      w_res_sat = 1'b0;
    end
  end
`else
  assign w_res_y   = w_fin_y;
  assign w_res_sat = w_fin_sat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  // S1: product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_p        <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_last  <= i_in_last;
      r_p        <= w_prod;
    end else if (w_advance) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2: accumulate, and on the last term finalize into the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_advance) begin
      if (r_s1_valid && r_s1_last) begin
        r_acc       <= '0;
        r_out_data  <= w_res_y;
        r_out_sat   <= w_res_sat;
        r_out_valid <= 1'b1;
      end else begin
        if (r_s1_valid) begin
          r_acc <= w_sum;
        end
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_sat   = r_out_sat;

endmodule
